csr_counter_unit: RTL

Machine counter/timer source for the CSR file: holds the 64-bit `mcycle`, `minstret` and `mtime` counters and the `mcountinhibit` register. It handles CSR writes to the writable counters and supplies the values that the CSR read-data multiplexer selects from. It sits directly upstream of that multiplexer and is fed by the CSR write path and by the retire signal from writeback.

---
 rtl/csr_counter_unit_pkg.sv | 42 ++++
 rtl/csr_counter_unit_counter64.sv | 48 ++++
 rtl/csr_counter_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/csr_counter_unit_pkg.sv
// Shared CSR constants for the machine counter block and the CSR read-data mux.
// Also provides the write decode used by the counter unit.
package csr_counter_unit_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

  typedef struct packed {
    logic mcycle_lo;
    logic mcycle_hi;
    logic minstret_lo;
    logic minstret_hi;
    logic inhibit;
  } csr_wr_dec_t;

  // One-hot write strobes; the read-only user aliases fall into the default arm.
  function automatic csr_wr_dec_t decode_wr(input logic wr_en, input logic [11:0] addr);
    csr_wr_dec_t dec;
    dec = '0;
    case (addr)
      CSR_MCYCLE:        dec.mcycle_lo   = wr_en;
      CSR_MCYCLEH:       dec.mcycle_hi   = wr_en;
      CSR_MINSTRET:      dec.minstret_lo = wr_en;
      CSR_MINSTRETH:     dec.minstret_hi = wr_en;
      CSR_MCOUNTINHIBIT: dec.inhibit     = wr_en;
      default:           dec = '0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/csr_counter_unit_counter64.sv
// 64-bit wrapping counter with 32-bit half writes; a write to either half
// suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] value_q;
  logic [63:0] value_d;

  // Next value: half writes take priority over the increment.
  always_comb begin
    value_d = value_q;
    if (wr_lo || wr_hi) begin
      if (wr_hi) begin
        value_d[63:32] = wdata;
      end else begin
        value_d[63:32] = value_q[63:32];
      end
      if (wr_lo) begin
        value_d[31:0] = wdata;
      end else begin
        value_d[31:0] = value_q[31:0];
      end
    end else if (inc) begin
      value_d = value_q + 64'd1;
    end else begin
      value_d = value_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 64'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/csr_counter_unit.sv
// Machine counters (mcycle, minstret, mtime) and mcountinhibit, feeding the
// CSR read-data mux. mtime advances once every TIME_DIV clocks.
module csr_counter_unit
  import csr_counter_unit_pkg::*;
#(
  parameter int unsigned TIME_DIV = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] data_wr_in,
  input  logic        instret_inc_in,
  output logic [63:0] mcycle_out,
  output logic [63:0] minstret_out,
  output logic [63:0] mtime_out,
  output logic [31:0] mcountinhibit_out
);

  localparam logic [15:0] PRESC_MAX = 16'(TIME_DIV - 1);

  csr_wr_dec_t wr_dec_s;
  logic [15:0] presc_q;
  logic [15:0] presc_d;
  logic [31:0] mcountinhibit_q;
  logic [31:0] mcountinhibit_d;
  logic        mtime_tick_s;
  logic        cycle_inc_s;
  logic        instret_inc_s;

  assign wr_dec_s = decode_wr(wr_en_in, csr_addr_in);

  // Prescaler wrap and inhibit-register next state.
  always_comb begin
    mtime_tick_s = (presc_q == PRESC_MAX);
    if (mtime_tick_s) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end
    if (wr_dec_s.inhibit) begin
      mcountinhibit_d = data_wr_in & MCOUNTINHIBIT_MASK;
    end else begin
      mcountinhibit_d = mcountinhibit_q;
    end
  end

  // Increment enables read the current inhibit, so a new value applies next cycle.
  assign cycle_inc_s   = ~mcountinhibit_q[0];
  assign instret_inc_s = instret_inc_in & ~mcountinhibit_q[2];

  // Prescaler and inhibit registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q         <= 16'd0;
      mcountinhibit_q <= 32'd0;
    end else begin
      presc_q         <= presc_d;
      mcountinhibit_q <= mcountinhibit_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (cycle_inc_s),
    .wr_lo (wr_dec_s.mcycle_lo),
    .wr_hi (wr_dec_s.mcycle_hi),
    .wdata (data_wr_in),
    .value (mcycle_out)
  );

  csr_counter64 u_minstret (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (instret_inc_s),
    .wr_lo (wr_dec_s.minstret_lo),
    .wr_hi (wr_dec_s.minstret_hi),
    .wdata (data_wr_in),
    .value (minstret_out)
  );

  csr_counter64 u_mtime (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (mtime_tick_s),
    .wr_lo (1'b0),
    .wr_hi (1'b0),
    .wdata (32'd0),
    .value (mtime_out)
  );

  assign mcountinhibit_out = mcountinhibit_q;

endmodule
